ram_access_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 32x32 single-port RAM between two requesters, A and B.
- The RAM has signals ena/wena/addr/data_in and a combinational data_out; this block drives those signals.
- Each requester issues single-word read or write transactions over a req/ack handshake.
- The block serialises the transactions, latches read data per requester and pulses ack on completion.

---
 rtl/ram_access_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port RAM between two
// requesters; each transaction runs IDLE -> ACCESS -> RESP with registered outputs.
module ram_access_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic                ram_ena_q, ram_ena_d;
    logic                ram_wena_q, ram_wena_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
    logic                busy_q, busy_d;
    logic                grant_b;

    // last_grant doubles as the identity of the requester currently in flight.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        ram_ena_d    = 1'b0;
        ram_wena_d   = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        grant_b      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    grant_b      = req_b && (!req_a || !last_grant_q);
                    last_grant_d = grant_b;
                    we_d         = grant_b ? we_b    : we_a;
                    ram_addr_d   = grant_b ? addr_b  : addr_a;
                    ram_wdata_d  = grant_b ? wdata_b : wdata_a;
                    ram_ena_d    = 1'b1;
                    ram_wena_d   = we_d;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    if (last_grant_q) rdata_b_d = ram_rdata;
                    else              rdata_a_d = ram_rdata;
                end
                ack_a_d = !last_grant_q;
                ack_b_d = last_grant_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            ram_ena_q    <= 1'b0;
            ram_wena_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            ram_ena_q    <= ram_ena_d;
            ram_wena_q   <= ram_wena_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
            busy_q       <= busy_d;
        end
    end

    assign ram_ena    = ram_ena_q;
    assign ram_wena   = ram_wena_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ack_a      = ack_a_q;
    assign ack_b      = ack_b_q;
    assign rdata_a    = rdata_a_q;
    assign rdata_b    = rdata_b_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

endmodule
